// File: rtl/zig_sample_collector.sv
// rtl/zig_sample_collector.sv - Ziggurat result classifier, tail-loop tracker and sample FIFO
// Accepted samples stream out through a valid/ready FIFO; discarded results request a redraw.
module zig_sample_collector #(
   parameter int DEPTH     = 16,
   parameter int LOG2DEPTH = 4,
   parameter int TAIL_MAX  = 8,
   parameter int CNT_W     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                res_valid,
   output logic                res_ready,
   input  logic                tail_case,
   input  logic                do_while,
   input  logic                reject,
   input  logic signed [35:0]  value,
   output logic                redraw,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [35:0]  out_data,
   output logic [CNT_W-1:0]    acc_cnt,
   output logic [CNT_W-1:0]    rej_cnt,
   output logic                tail_err
);

   localparam int CW   = LOG2DEPTH + 1;
   localparam int TI_W = (TAIL_MAX > 2) ? $clog2(TAIL_MAX) : 1;

   typedef enum logic {NORMAL, TAIL} state_t;

   state_t                state_q, state_d;
   logic [TI_W-1:0]       tail_iter_q, tail_iter_d;
   logic                  redraw_q, redraw_d;
   logic                  tail_err_q, tail_err_d;
   logic [CNT_W-1:0]      acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0]      rej_cnt_q, rej_cnt_d;
   logic [LOG2DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LOG2DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LOG2DEPTH-1:0]  rd_nxt;
   logic [CW-1:0]         count_q, count_d;
   logic signed [35:0]    out_data_q, out_data_d;
   logic signed [35:0]    mem_q [DEPTH];

   logic consume, push, pop, acc_inc, rej_inc;

   assign res_ready = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign out_data  = out_data_q;
   assign redraw    = redraw_q;
   assign acc_cnt   = acc_cnt_q;
   assign rej_cnt   = rej_cnt_q;
   assign tail_err  = tail_err_q;

   assign consume = res_valid && res_ready;
   assign pop     = out_valid && out_ready;
   assign rd_nxt  = rd_ptr_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      tail_iter_d = tail_iter_q;
      redraw_d    = 1'b0;
      tail_err_d  = tail_err_q;
      push        = 1'b0;
      acc_inc     = 1'b0;
      rej_inc     = 1'b0;
      if (consume) begin
         state_d     = NORMAL;
         tail_iter_d = '0;
         if (state_q == TAIL && !tail_case) begin
            tail_err_d = 1'b1;
            rej_inc    = 1'b1;
            redraw_d   = 1'b1;
         end else if (reject) begin
            rej_inc  = 1'b1;
            redraw_d = 1'b1;
         end else if (tail_case && do_while) begin
            redraw_d = 1'b1;
            // Abort a tail loop that would exceed TAIL_MAX iterations
            if (state_q == TAIL && tail_iter_q == TI_W'(TAIL_MAX - 1)) begin
               tail_err_d = 1'b1;
               rej_inc    = 1'b1;
            end else begin
               state_d     = TAIL;
               tail_iter_d = tail_iter_q + 1'b1;
            end
         end else begin
            push    = 1'b1;
            acc_inc = 1'b1;
         end
      end
   end

   always_comb begin
      acc_cnt_d = acc_cnt_q;
      rej_cnt_d = rej_cnt_q;
      if (acc_inc && acc_cnt_q != {CNT_W{1'b1}}) acc_cnt_d = acc_cnt_q + 1'b1;
      if (rej_inc && rej_cnt_q != {CNT_W{1'b1}}) rej_cnt_d = rej_cnt_q + 1'b1;
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_nxt : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      out_data_d = out_data_q;
      // Head register tracks the next head so out_data holds its value once drained
      if (count_d != '0) begin
         if (count_q == '0)
            out_data_d = value;
         else if (pop)
            out_data_d = (count_q == CW'(1)) ? value : mem_q[rd_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= value;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= NORMAL;
         tail_iter_q <= '0;
         redraw_q    <= 1'b0;
         tail_err_q  <= 1'b0;
         acc_cnt_q   <= '0;
         rej_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         tail_iter_q <= tail_iter_d;
         redraw_q    <= redraw_d;
         tail_err_q  <= tail_err_d;
         acc_cnt_q   <= acc_cnt_d;
         rej_cnt_q   <= rej_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: doc/zig_sample_collector.md
Name: zig_sample_collector

Overview:
- Sits downstream of the Ziggurat OpUnit and consumes its per-cycle verdicts: tail_case, do_while, reject and value (Q7.28).
- Discards rejected samples and tracks tail-loop iterations.
- Buffers accepted Gaussian samples in a FIFO that drives a valid/ready output stream to the consumer.
- Issues a one-cycle redraw request to the front end whenever a result does not yield a sample.

Parameters:
- DEPTH, 16, FIFO depth in samples (power of two, >=2).
- LOG2DEPTH, 4, log2(DEPTH).
- TAIL_MAX, 8, maximum consecutive tail iterations before the loop is aborted.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- res_valid  in  1  OpUnit result valid this cycle.
- res_ready  out  1  collector can take a result; equals !full.
- tail_case  in  1  result belongs to the tail (rect_idx 0) path.
- do_while  in  1  tail loop must iterate again.
- reject  in  1  result rejected.
- value  in  36  signed Q7.28 candidate sample.
- redraw  out  1  registered pulse requesting new random operands.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head sample.
- out_data  out  36  signed Q7.28 head sample.
- acc_cnt  out  CNT_W  accepted samples (saturating).
- rej_cnt  out  CNT_W  rejected plus aborted results (saturating).
- tail_err  out  1  sticky: tail abort or protocol violation.

Behaviour:
- Reset (asynchronous, active-high) clears everything: FIFO empty, out_valid=0, out_data=0, res_ready=1, redraw=0, acc_cnt=0, rej_cnt=0, tail_err=0, state=NORMAL, tail_iter=0.
- Reset asserted mid-operation drops all buffered samples immediately.
- A result is consumed in a cycle when res_valid && res_ready. Otherwise all inputs are ignored and no state changes.
- Classification of a consumed result, in priority order:
  1. reject=1: discard, rej_cnt+1, redraw=1.
  2. tail_case=1 && do_while=1: discard, redraw=1; state->TAIL, tail_iter+1.
  3. Otherwise: push value, acc_cnt+1, redraw=0.
- State NORMAL: classification as above. tail_iter is 0.
- State TAIL:
  - Consumed result with tail_case=0: protocol violation. Set tail_err, discard, rej_cnt+1, redraw=1, state->NORMAL, tail_iter=0.
  - Tail continuation (rule 2) when tail_iter==TAIL_MAX-1: abort instead. Set tail_err, rej_cnt+1, redraw=1, state->NORMAL, tail_iter=0.
  - Accept (rule 3) or reject (rule 1): state->NORMAL, tail_iter=0.
- redraw is registered: it is high in the cycle after the consuming edge and lasts one cycle. It is 0 in every cycle where nothing is consumed.
- FIFO:
  - Push and pop take effect at the clock edge.
  - out_data is the head, valid whenever out_valid=1. out_data holds its last value when empty.
  - Pop when out_valid && out_ready.
  - Pointers are LOG2DEPTH bits and wrap modulo DEPTH. Occupancy counter is LOG2DEPTH+1 bits.
  - Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, order preserved.
  - When empty: a push becomes visible at out_valid the next cycle (no fall-through).
  - When full: res_ready=0, so no push is possible even if a pop happens the same cycle.
- Latency: result consumed at edge N -> sample visible on out_data/out_valid after edge N.
- Counters saturate at 2^CNT_W-1 and never wrap.
- value is passed through bit-exact. There is no rounding or truncation.

Test Plan:
- Normal accept: tail_case=0, do_while=0, reject=0, value=36'sh5_38F5_A36B, out_ready=1 -> next cycle out_valid=1, out_data=36'sh5_38F5_A36B, acc_cnt=1, redraw=0.
- Reject: reject=1, value=36'shB_0865_D8A3 -> FIFO stays empty, rej_cnt=1, redraw pulses for exactly one cycle.
- Tail loop: three results with tail_case=1, do_while=1, then one with tail_case=1, do_while=0, value=36'sh0_02BD_0915 -> three redraw pulses; one sample 36'sh0_02BD_0915 output; state returns to NORMAL; tail_err=0.
- Tail abort: eight consecutive tail_case=1, do_while=1 results (TAIL_MAX=8) -> 8th result sets tail_err=1, rej_cnt=1, state NORMAL; a following tail_case=0 result is accepted normally.
- FIFO full and wrap:
  - Push 16 samples 1..16 with out_ready=0 -> res_ready=0.
  - Push attempt while full is ignored.
  - Then out_ready=1 with a continuous push of 17..40 -> output order is exactly 1..40, none lost or duplicated.
- Asynchronous reset: assert rst between clock edges with 5 samples queued -> out_valid, redraw, counters and tail_err drop to 0 immediately, without waiting for a clock edge.
